// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/handshake bundle between the fetch/execute sequencer and the datapath.
// Inputs to the sequencer: run, mem_ready, exec_done, branch_taken, halt_req.
// Outputs from the sequencer: pc_increment, pc_load, mar_load, mem_read, ir_load, exec_start,
// halted, fault, state[2:0], instr_count[COUNT_WIDTH-1:0].
// master = sequencer side, slave = datapath/environment side.
interface pc_sequencer_if #(parameter int COUNT_WIDTH = 32);
    logic                   run;
    logic                   mem_ready;
    logic                   exec_done;
    logic                   branch_taken;
    logic                   halt_req;
    logic                   pc_increment;
    logic                   pc_load;
    logic                   mar_load;
    logic                   mem_read;
    logic                   ir_load;
    logic                   exec_start;
    logic                   halted;
    logic                   fault;
    logic [2:0]             state;
    logic [COUNT_WIDTH-1:0] instr_count;
    modport master (
        input  run, mem_ready, exec_done, branch_taken, halt_req,
        output pc_increment, pc_load, mar_load, mem_read, ir_load, exec_start,
               halted, fault, state, instr_count
    );
    modport slave (
        output run, mem_ready, exec_done, branch_taken, halt_req,
        input  pc_increment, pc_load, mar_load, mem_read, ir_load, exec_start,
               halted, fault, state, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute controller driving PC, MAR, memory read and IR strobes.
// Ports: clock (rising-edge), clear (sync active-high reset), bus (pc_sequencer_if.master).
// Strobes are Moore decodes of state; instr_count counts retired instructions; fault flags a
// memory read that waited MEM_TIMEOUT cycles in FETCH1.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 32
) (
    input logic              clock,
    input logic              clear,
    pc_sequencer_if.master   bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH0 = 3'd1;
    localparam logic [2:0] FETCH1 = 3'd2;
    localparam logic [2:0] FETCH2 = 3'd3;
    localparam logic [2:0] EXEC   = 3'd4;
    localparam logic [2:0] BRANCH = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;
    localparam logic [2:0] FAULT  = 3'd7;
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [2:0]             state;
    logic [2:0]             next;
    logic [7:0]             wait_cnt;
    logic                   first;
    logic [COUNT_WIDTH-1:0] count;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.run ? FETCH0 : IDLE;
            FETCH0:  next = FETCH1;
            // mem_ready in the last allowed cycle still beats the timeout
            FETCH1:  next = bus.mem_ready ? FETCH2 : (wait_cnt == LAST_WAIT ? FAULT : FETCH1);
            FETCH2:  next = EXEC;
            EXEC:    next = !bus.exec_done ? EXEC :
                            bus.halt_req ? HALT :
                            bus.branch_taken ? BRANCH :
                            bus.run ? FETCH0 : IDLE;
            BRANCH:  next = FETCH0;
            default: next = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            first    <= 1'b0;
            count    <= '0;
        end else begin
            state    <= next;
            // zero whenever outside FETCH1, so every FETCH1 visit starts from 0
            wait_cnt <= (state == FETCH1 && !bus.mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            // EXEC is only entered from FETCH2, so this marks the first EXEC cycle
            first    <= (state == FETCH2);
            if (state == EXEC && bus.exec_done)
                count <= count + COUNT_WIDTH'(1);
        end
    end

    assign bus.pc_increment = (state == FETCH0);
    assign bus.mar_load     = (state == FETCH0);
    assign bus.mem_read     = (state == FETCH1);
    assign bus.ir_load      = (state == FETCH2);
    assign bus.exec_start   = (state == EXEC) && first;
    assign bus.pc_load      = (state == BRANCH);
    assign bus.halted       = (state == HALT);
    assign bus.fault        = (state == FAULT);
    assign bus.state        = state;
    assign bus.instr_count  = count;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table vectors, hand sequences and random stimulus against a reference model.
module tb_pc_sequencer;
    localparam int T  = 4;
    localparam int CW = 32;
    localparam logic [10:0] S_IDLE = {3'd0, 8'b0000_0000};
    localparam logic [10:0] S_F0   = {3'd1, 8'b1010_0000};
    localparam logic [10:0] S_F1   = {3'd2, 8'b0001_0000};
    localparam logic [10:0] S_F2   = {3'd3, 8'b0000_1000};
    localparam logic [10:0] S_EX1  = {3'd4, 8'b0000_0100};
    localparam logic [10:0] S_EX0  = {3'd4, 8'b0000_0000};
    localparam logic [10:0] S_BR   = {3'd5, 8'b0100_0000};
    localparam logic [10:0] S_HALT = {3'd6, 8'b0000_0010};

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    pc_sequencer_if #(.COUNT_WIDTH(CW)) bus();
    pc_sequencer #(.MEM_TIMEOUT(T), .COUNT_WIDTH(CW)) dut (.clock(clock), .clear(clear), .bus(bus));

    wire [10:0] outs = {bus.state, bus.pc_increment, bus.pc_load, bus.mar_load, bus.mem_read,
                        bus.ir_load, bus.exec_start, bus.halted, bus.fault};

    int vectors = 0;
    int miscompares = 0;

    int          m_phase = 0;
    int          m_waited = 0;
    bit          m_fresh = 0;
    logic [CW-1:0] m_count = '0;

    typedef struct {
        logic [5:0]    in;
        logic [10:0]   exp;
        logic [CW-1:0] cnt;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] model_outs();
        int p = m_phase;
        return {3'(p), p == 1, p == 5, p == 1, p == 2, p == 3, p == 4 && m_fresh, p == 6, p == 7};
    endfunction

    task automatic model_step(input bit c, r, mr, ed, br, hr);
        bit nf = 0;
        if (c) begin
            m_phase = 0; m_waited = 0; m_count = '0;
        end else begin
            case (m_phase)
                0: if (r) m_phase = 1;
                1: begin m_phase = 2; m_waited = 0; end
                2: if (mr) m_phase = 3;
                   else if (m_waited == T - 1) m_phase = 7;
                   else m_waited++;
                3: begin m_phase = 4; nf = 1; end
                4: if (ed) begin
                       m_count++;
                       m_phase = hr ? 6 : br ? 5 : r ? 1 : 0;
                   end
                5: m_phase = 1;
                default: ;
            endcase
        end
        m_fresh = nf;
    endtask

    task automatic drive(input bit c, r, mr, ed, br, hr);
        clear = c; bus.run = r; bus.mem_ready = mr;
        bus.exec_done = ed; bus.branch_taken = br; bus.halt_req = hr;
        model_step(c, r, mr, ed, br, hr);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, "_outs"}, 64'(outs), 64'(model_outs()));
        check({name, "_count"}, 64'(bus.instr_count), 64'(m_count));
    endtask

    task automatic to_exec(input string name);
        drive(0, 1, 0, 0, 0, 0); check_model(name);
        drive(0, 1, 0, 0, 0, 0); check_model(name);
        drive(0, 1, 1, 0, 0, 0); check_model(name);
        drive(0, 1, 0, 0, 0, 0); check_model(name);
    endtask

    initial begin
        bus.run = 0; bus.mem_ready = 0; bus.exec_done = 0; bus.branch_taken = 0; bus.halt_req = 0;
        // in = {clear, run, mem_ready, exec_done, branch_taken, halt_req}
        tbl[0]  = '{6'b100000, S_IDLE, 0};
        tbl[1]  = '{6'b010000, S_F0,   0};
        tbl[2]  = '{6'b011100, S_F1,   0};
        tbl[3]  = '{6'b011000, S_F2,   0};
        tbl[4]  = '{6'b010000, S_EX1,  0};
        tbl[5]  = '{6'b010100, S_F0,   1};
        tbl[6]  = '{6'b010000, S_F1,   1};
        tbl[7]  = '{6'b011000, S_F2,   1};
        tbl[8]  = '{6'b010000, S_EX1,  1};
        tbl[9]  = '{6'b010110, S_BR,   2};
        tbl[10] = '{6'b000000, S_F0,   2};
        tbl[11] = '{6'b010000, S_F1,   2};
        tbl[12] = '{6'b011000, S_F2,   2};
        tbl[13] = '{6'b010000, S_EX1,  2};
        tbl[14] = '{6'b010000, S_EX0,  2};
        tbl[15] = '{6'b010111, S_HALT, 3};
        tbl[16] = '{6'b011100, S_HALT, 3};
        tbl[17] = '{6'b100000, S_IDLE, 0};
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            check($sformatf("tbl%0d_outs", i), 64'(outs), 64'(tbl[i].exp));
            check($sformatf("tbl%0d_count", i), 64'(bus.instr_count), 64'(tbl[i].cnt));
        end

        // three mem_ready=0 cycles then ready in the last allowed cycle: no fault
        drive(1, 0, 0, 0, 0, 0); check_model("wait_clr");
        drive(0, 1, 0, 0, 0, 0); check_model("wait_f0");
        drive(0, 1, 0, 0, 0, 0); check("wait_enter", 64'(bus.state), 64'd2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            check("wait_hold", 64'({bus.state, bus.fault}), 64'({3'd2, 1'b0}));
        end
        drive(0, 1, 1, 0, 0, 0);
        check("wait_irload", 64'({bus.state, bus.ir_load}), 64'({3'd3, 1'b1}));
        drive(0, 1, 0, 0, 0, 0);
        check("wait_exec", 64'({bus.state, bus.ir_load, bus.exec_start}), 64'({3'd4, 1'b0, 1'b1}));

        // timeout: four FETCH1 cycles without mem_ready
        drive(1, 0, 0, 0, 0, 0); check_model("to_clr");
        drive(0, 1, 0, 0, 0, 0); check_model("to_f0");
        drive(0, 1, 0, 0, 0, 0); check_model("to_f1");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            check("to_hold", 64'({bus.state, bus.fault}), 64'({3'd2, 1'b0}));
        end
        drive(0, 1, 0, 0, 0, 0);
        check("to_fault", 64'({bus.state, bus.fault}), 64'({3'd7, 1'b1}));
        drive(0, 1, 1, 1, 0, 0);
        check("to_sticky", 64'({bus.state, bus.fault}), 64'({3'd7, 1'b1}));
        drive(1, 1, 1, 0, 0, 0);
        check("to_clear", 64'({bus.state, bus.fault}), 64'({3'd0, 1'b0}));

        // clear in EXEC after exec_start, then a fresh exec_start
        to_exec("cx_a");
        drive(0, 1, 0, 1, 0, 0); check_model("cx_retire");
        drive(0, 1, 0, 0, 0, 0); drive(0, 1, 1, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
        check("cx_start", 64'(bus.exec_start), 64'd1);
        drive(0, 1, 0, 0, 0, 0);
        check("cx_nostart", 64'(bus.exec_start), 64'd0);
        drive(1, 1, 0, 1, 0, 0);
        check("cx_clear", 64'({bus.state, bus.instr_count}), 64'({3'd0, 32'd0}));
        drive(0, 1, 0, 0, 0, 0);
        to_exec("cx_b");
        check("cx_fresh", 64'(bus.exec_start), 64'd1);

        // run dropped before retire: back to IDLE, count still advances
        drive(0, 0, 0, 1, 0, 0);
        check("rd_idle", 64'({bus.state, bus.instr_count}), 64'({3'd0, 32'd1}));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 1, 0);
            check("rd_noinc", 64'({bus.state, bus.pc_increment}), 64'({3'd0, 1'b0}));
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            check_model($sformatf("rnd%0d", i));
            check("inv_pc", 64'(bus.pc_increment & bus.pc_load), 64'd0);
            check("inv_load", 64'($countones({bus.mar_load, bus.ir_load, bus.pc_load}) <= 1), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute controller that sequences the program counter register, MAR, memory read and IR load for the CPU datapath. It drives the PC's increment and load-enable strobes, waits on a memory ready handshake, hands each fetched instruction to the execute stage and redirects the PC on taken branches. It also retires a running instruction count and flags memory-timeout faults.

## Interface
- MEM_TIMEOUT, 16: max FETCH1 cycles without mem_ready before fault; legal range 2..255.
- COUNT_WIDTH, 32: width of the retired-instruction counter.

- clock  input  1  system clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset.
- run  input  1  start/continue request; sampled in IDLE and at instruction retire.
- mem_ready  input  1  memory read data valid; sampled in FETCH1.
- exec_done  input  1  execute stage finished the current instruction; sampled in EXEC.
- branch_taken  input  1  current instruction redirects the PC; qualified by exec_done.
- halt_req  input  1  current instruction is HALT; qualified by exec_done.
- pc_increment  output  1  to PC increment strobe.
- pc_load  output  1  to PC enable, loads the branch target.
- mar_load  output  1  MAR captures the current PC.
- mem_read  output  1  memory read request.
- ir_load  output  1  IR captures memory data.
- exec_start  output  1  one-cycle start pulse to the execute stage.
- halted  output  1  sequencer is in HALT.
- fault  output  1  memory timeout; sticky until clear.
- state  output  3  current state encoding, for debug.
- instr_count  output  COUNT_WIDTH  retired instructions.

## Operation
- States and encodings: IDLE=0, FETCH0=1, FETCH1=2, FETCH2=3, EXEC=4, BRANCH=5, HALT=6, FAULT=7.
- All strobes are Moore decodes of the registered state, so they are asserted for exactly the cycles spent in the state.
- IDLE: all strobes 0. Goes to FETCH0 when run=1, otherwise stays.
- FETCH0: mar_load=1 and pc_increment=1 for one cycle. MAR captures the old PC at the same edge the PC advances. Next state is FETCH1.
- FETCH1: mem_read=1.
  - Wait counter is cleared on entry and increments each cycle mem_ready=0.
  - If mem_ready=1, go to FETCH2.
  - Otherwise, if the counter has reached MEM_TIMEOUT-1, go to FAULT.
  - mem_ready in the timeout cycle wins over the fault.
- FETCH2: ir_load=1 for one cycle. Next state is EXEC.
- EXEC: exec_start=1 on the first EXEC cycle only. Holds until exec_done=1; exec_done in the first cycle is legal. On exec_done, priority is:
  - halt_req goes to HALT;
  - else branch_taken goes to BRANCH;
  - else run=1 goes to FETCH0;
  - else goes to IDLE.
- BRANCH: pc_load=1 for one cycle. Always goes to FETCH0; run is not checked.
- HALT: halted=1. Left only via clear.
- FAULT: fault=1. Left only via clear.
- instr_count increments by 1 on every cycle where state=EXEC and exec_done=1, including halting and branching instructions. It wraps modulo 2^COUNT_WIDTH.
- Invariants:
  - pc_increment and pc_load are never both 1.
  - At most one of mar_load, ir_load, pc_load is 1 in any cycle.

## Timing
- Reset: clear=1 at an edge forces IDLE from any state, including mid-FETCH1 wait, HALT and FAULT. After that edge:
  - all strobes, halted and fault are 0;
  - state is 0 and instr_count is 0;
  - the wait counter is 0 and the exec_start flag is re-armed.
- clear has priority over every other input.
- Minimum instruction with no memory wait and exec_done on the first EXEC cycle takes 4 cycles: FETCH0, FETCH1, FETCH2, EXEC. A taken branch adds 1 cycle (BRANCH).
- Each mem_ready=0 cycle in FETCH1 adds 1 cycle.
- The first FETCH0 begins 1 cycle after the edge that samples run=1 in IDLE.
- exec_done outside EXEC, and mem_ready outside FETCH1, are ignored.

## Test plan
- Reset, then run=1, mem_ready=1, exec_done=1 on each EXEC cycle for 3 instructions:
  - pc_increment pulses at cycles 1, 5, 9;
  - instr_count=3 after cycle 12;
  - no pc_load.
- mem_ready held 0 for 3 FETCH1 cycles, then 1: FETCH1 lasts 4 cycles, no fault, then ir_load pulses once.
- mem_ready held 0 with MEM_TIMEOUT=4: fault=1 and state=7 after 4 FETCH1 cycles; fault stays high until clear, then state=0 and fault=0.
- exec_done with branch_taken=1 and halt_req=0: one pc_load pulse in BRANCH, then FETCH0. exec_done with branch_taken=1 and halt_req=1: HALT, halted=1, no pc_load.
- run dropped before exec_done: state returns to IDLE after retire, instr_count still increments, and no further pc_increment occurs.
- clear asserted in EXEC after exec_start: next cycle state=0 and instr_count=0. Re-running produces a fresh exec_start pulse.
